// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: control+data bundle, valid/ready, 2-entry skid, sync flush.
// Latency 1 cycle, 1 entry/cycle; InReady is registered (skid empty), so OutReady never reaches it combinationally.
// Optional StallCnt/FlushCnt performance counters are built only when PERF_CNT_EN is defined.
module pipe_stage_elastic #(
    parameter int              CTRL_W      = 16,
    parameter int              DATA_W      = 128,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int              CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    input  logic              Flush
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    logic              main_vld_q,  main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q,  skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_rdy_q,    in_rdy_d;

    logic acc;
    logic drn;

    assign acc = InValid & in_rdy_q;
    assign drn = main_vld_q & OutReady;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (Flush) begin
            // Payload registers keep their contents; only the valid bits are squashed.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (acc) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = InCtrl;
                main_data_d = InData;
            end
        end else if (!skid_vld_q) begin
            if (acc && drn) begin
                main_ctrl_d = InCtrl;
                main_data_d = InData;
            end else if (acc) begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = InCtrl;
                skid_data_d = InData;
            end else if (drn) begin
                main_vld_d  = 1'b0;
            end
        end else if (drn) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
        end

        in_rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_rdy_q    <= 1'b1;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_rdy_q    <= in_rdy_d;
        end
    end

    assign InReady  = in_rdy_q;
    assign OutValid = main_vld_q;
    // Mask keeps RegWrite/MemWrite-style bits from leaking out of a bubble.
    assign OutCtrl  = main_vld_q ? main_ctrl_q : BUBBLE_CTRL;
    assign OutData  = main_data_q;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_vld_q && !OutReady && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (Flush && (main_vld_q || skid_vld_q || InValid) && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed plan scenarios then random traffic against a queue reference model.
module tb_pipe_stage_elastic;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld;
    logic              in_rdy;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_dat;
    logic              out_vld;
    logic              out_rdy;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_dat;
    logic              flush;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .BUBBLE_CTRL({CTRL_W{1'b0}}),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .InValid (in_vld),
        .InReady (in_rdy),
        .InCtrl  (in_ctrl),
        .InData  (in_dat),
        .OutValid(out_vld),
        .OutReady(out_rdy),
        .OutCtrl (out_ctrl),
        .OutData (out_dat),
        .Flush   (flush)
`ifdef PERF_CNT_EN
        ,
        .StallCnt(stall_cnt),
        .FlushCnt(flush_cnt)
`endif
    );

    // Reference model: the stage is a FIFO of capacity 2 whose head is the output.
    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_stall;
    int                m_flush;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                              input logic ordy, input logic fl, input logic rn);
        bit was_full;
        ent_t e;
        if (!rn) begin
            mq.delete();
            m_last  = '0;
            m_stall = 0;
            m_flush = 0;
            return;
        end
        if (mq.size() > 0 && !ordy && m_stall < CNT_MAX) m_stall++;
        if (fl && (mq.size() > 0 || iv) && m_flush < CNT_MAX) m_flush++;
        if (fl) begin
            mq.delete();
            return;
        end
        was_full = (mq.size() == 2);
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (iv && !was_full) begin
            e.c = ic;
            e.d = id;
            mq.push_back(e);
        end
        if (mq.size() > 0) m_last = mq[0].d;
    endtask

    task automatic check_all();
        logic              e_vld;
        logic [CTRL_W-1:0] e_ctrl;
        e_vld  = (mq.size() > 0);
        e_ctrl = e_vld ? mq[0].c : '0;
        chk("out_vld",  {127'b0, out_vld},  {127'b0, e_vld});
        chk("in_rdy",   {127'b0, in_rdy},   {127'b0, (mq.size() < 2)});
        chk("out_ctrl", {112'b0, out_ctrl}, {112'b0, e_ctrl});
        chk("out_dat",  out_dat, m_last);
`ifdef PERF_CNT_EN
        chk("stall_cnt", {124'b0, stall_cnt}, DATA_W'(m_stall));
        chk("flush_cnt", {124'b0, flush_cnt}, DATA_W'(m_flush));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
    task automatic cyc(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                       input logic ordy, input logic fl, input logic rn);
        in_vld  = iv;
        in_ctrl = ic;
        in_dat  = id;
        out_rdy = ordy;
        flush   = fl;
        rst_n   = rn;
        @(posedge clk);
        model_edge(iv, ic, id, ordy, fl, rn);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        in_vld = 0; in_ctrl = '0; in_dat = '0; out_rdy = 0; flush = 0; rst_n = 0;
        mq.delete(); m_last = '0; m_stall = 0; m_flush = 0;
        @(negedge clk);

        // Reset state
        cyc(1, 16'h1234, 128'h99, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        chk("rst_out_dat", out_dat, '0);
        chk("rst_in_rdy", {127'b0, in_rdy}, 128'd1);

        // Streaming 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 16'h0011, DATA_W'(i), 1, 0, 1);
            chk("stream_dat", out_dat, DATA_W'(i));
        end
        cyc(0, '0, '0, 1, 0, 1);

        // Skid fill: 0xA accepted, then stall while 0xB and 0xC are offered
        cyc(1, 16'h000A, 128'hA, 1, 0, 1);
        cyc(1, 16'h000B, 128'hB, 0, 0, 1);
        cyc(1, 16'h000C, 128'hC, 0, 0, 1);
        chk("skid_full_rdy", {127'b0, in_rdy}, 128'd0);
        chk("skid_head", out_dat, 128'hA);
        cyc(1, 16'h000C, 128'hC, 0, 0, 1);
        cyc(1, 16'h000C, 128'hC, 1, 0, 1);
        chk("skid_drain_b", out_dat, 128'hB);
        cyc(1, 16'h000C, 128'hC, 1, 0, 1);
        cyc(0, '0, '0, 1, 0, 1);
        chk("skid_drain_c", out_dat, 128'hC);
        cyc(0, '0, '0, 1, 0, 1);

        // Bubble masking
        cyc(0, 16'hFFFF, 128'h77, 1, 0, 1);
        chk("bubble_ctrl", {112'b0, out_ctrl}, 128'd0);
        cyc(1, 16'hFFFF, 128'h78, 1, 0, 1);
        chk("pulse_ctrl", {112'b0, out_ctrl}, 128'hFFFF);
        cyc(0, 16'hFFFF, 128'h79, 1, 0, 1);
        chk("pulse_end_ctrl", {112'b0, out_ctrl}, 128'd0);

        // Flush in FULL with an entry offered
        cyc(1, 16'h0101, 128'h101, 0, 0, 1);
        cyc(1, 16'h0202, 128'h202, 0, 0, 1);
        cyc(1, 16'h0303, 128'h303, 0, 1, 1);
        chk("flush_vld", {127'b0, out_vld}, 128'd0);
        cyc(0, '0, '0, 1, 0, 1);
        cyc(0, '0, '0, 1, 0, 1);

        // Reset mid-operation from FULL, coinciding with Flush
        cyc(1, 16'h0404, 128'h404, 0, 0, 1);
        cyc(1, 16'h0505, 128'h505, 0, 0, 1);
        cyc(1, 16'h0606, 128'h606, 0, 1, 0);
        chk("rst_mid_dat", out_dat, '0);
        cyc(1, 16'h0055, 128'h55, 1, 0, 1);
        chk("post_rst_dat", out_dat, 128'h55);
        cyc(0, '0, '0, 1, 0, 1);

        // Long stall: stall counter saturates
        cyc(1, 16'h0707, 128'h707, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, '0, '0, 0, 0, 1);
        chk("stall_hold_vld", {127'b0, out_vld}, 128'd1);
        cyc(0, '0, '0, 1, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0,
                CTRL_W'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries a control bundle and a data bundle between two pipeline stages, with valid/ready handshake, a 2-entry skid buffer and a synchronous flush for branch/jump squash.
- Drops in at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), so stalls and bubbles are handled in the stage register and no longer by ad-hoc muxing in the datapath.

Parameters:
- CTRL_W, 16, width of the control bundle (RegWrite, MemWrite, ALUOp, ...), forced to BUBBLE_CTRL when the stage is empty.
- DATA_W, 128, width of the data bundle (PC, operands, immediate, register indices).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented on OutCtrl whenever OutValid=0.
- CNT_W, 16, performance counter width (used only with PERF_CNT_EN).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- InValid  input  1  upstream presents a valid entry.
- InReady  output  1  stage can accept an entry; registered, equals skid buffer empty.
- InCtrl  input  CTRL_W  upstream control bundle.
- InData  input  DATA_W  upstream data bundle.
- OutValid  output  1  main register holds a valid entry.
- OutReady  input  1  downstream accepts (low = downstream stall).
- OutCtrl  output  CTRL_W  main control, or BUBBLE_CTRL when OutValid=0.
- OutData  output  DATA_W  main data; holds last value when invalid.
- Flush  input  1  squash all held entries and any entry offered this cycle.
- StallCnt  output  CNT_W  PERF_CNT_EN only.
- FlushCnt  output  CNT_W  PERF_CNT_EN only.

Behaviour:
- Single clock domain (Clk). Reset is synchronous and active-low: Rst_n sampled low at a rising Clk edge resets the block.
- Handshake terms:
  - acc = InValid & InReady.
  - drn = OutValid & OutReady.
- Latency and throughput:
  - Latency 1 cycle: an entry accepted at edge N appears on Out* after edge N.
  - Throughput 1 entry/cycle while OutReady=1.
- States: EMPTY (main and skid invalid), ONE (main valid), FULL (main and skid valid).
- Transitions, evaluated at each rising Clk:
  - EMPTY: acc -> ONE, main<=In.
  - ONE:
    - acc & drn -> ONE, main<=In.
    - acc & !drn -> FULL, skid<=In.
    - !acc & drn -> EMPTY.
    - else hold.
  - FULL (InReady=0, so acc is impossible): drn -> ONE, main<=skid; else hold.
- Entries leave in acceptance order. No entry is duplicated or dropped except by Flush.
- InValid is sampled only when InReady=1. If InReady=0, In* are ignored.
- Flush:
  - Next state EMPTY.
  - Discards main, skid and any entry offered in the same cycle.
  - Takes priority over acc/drn.
  - A drn coinciding with Flush still counts as delivered downstream; the block does not retract it.
- Reset:
  - Rst_n=0 at an edge -> EMPTY.
  - All output registers go to 0: OutValid=0, InReady=1 (after reset edge), OutCtrl=BUBBLE_CTRL, OutData=0, counters=0.
  - Reset has priority over Flush and the handshake.
  - Reset mid-transfer discards all entries.
- OutCtrl is masked combinationally from the registered main control, so no RegWrite/MemWrite pulse can leak from a bubble.
- OutValid and InReady are pure register outputs. There is no combinational In*->Out* path.
- OutReady->InReady has no combinational path, which breaks the stall chain.

Optional Feature:
- PERF_CNT_EN defined:
  - StallCnt increments each cycle with OutValid=1 & OutReady=0.
  - FlushCnt increments each cycle with Flush=1 while (OutValid | skid valid | InValid) = 1.
  - Both counters saturate at all-ones and reset to 0.
- PERF_CNT_EN undefined:
  - StallCnt/FlushCnt ports absent.
  - No counter logic is synthesised.
  - Handshake behaviour is identical.

Test Plan:
- Streaming: InValid=1, OutReady=1, InData=1,2,3,4 on consecutive cycles -> OutData 1,2,3,4 one cycle later, OutValid=1 throughout, InReady never deasserts.
- Skid fill: stream 0xA,0xB,0xC with OutReady=0 from the cycle 0xA appears -> 0xA held, 0xB in skid, InReady=0 next cycle, 0xC held upstream. OutReady=1 -> outputs 0xA,0xB,0xC in order, no loss.
- Bubble masking: InCtrl=16'hFFFF, InValid=0 -> OutCtrl=BUBBLE_CTRL=16'h0000, OutValid=0. Then InValid=1 pulse -> OutCtrl=16'hFFFF for exactly one cycle.
- Flush in FULL state with InValid=1 -> next cycle OutValid=0, InReady=1, OutCtrl=0. Offered entry never appears. With PERF_CNT_EN, FlushCnt=1.
- Reset mid-operation: FULL state, Rst_n=0 for one edge (Flush=1 simultaneously) -> OutValid=0, OutData=0, InReady=1, counters=0. First post-reset entry 0x55 passes with latency 1.
- Counter saturation (PERF_CNT_EN, CNT_W=4): OutValid=1, OutReady=0 for 20 cycles -> StallCnt reads 15 and holds.
